exec_unit: RTL and testbench

Execute stage of the 8-bit accumulator core, downstream of the instruction cycle controller. It consumes the one-cycle execute strobe together with the instruction register, immediate buffer and memory buffer. It owns the accumulator (AR), the multiply high byte (AH) and the 4-bit flag register, and feeds AR and Flags back to the controller for stores and conditional jumps. Single-cycle ALU ops complete on the strobe edge. An iterative multiplier runs for DATA_WIDTH cycles, backed by a one-deep pending slot.

---
 rtl/exec_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_exec_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// Execute stage of the 8-bit accumulator core: single-cycle ALU, iterative shift-add
// multiplier and a one-deep pending slot for instructions that arrive while it runs.
module exec_unit #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  exec,
  input  logic [DATA_WIDTH-1:0] ir,
  input  logic [DATA_WIDTH-1:0] ibr,
  input  logic [DATA_WIDTH-1:0] mbr,
  output logic [DATA_WIDTH-1:0] ar,
  output logic [DATA_WIDTH-1:0] ah,
  output logic [3:0]            flags,
  output logic                  busy,
  output logic                  ovr
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  typedef struct packed {
    logic [W-1:0] r;
    logic [3:0]   fl;
  } alu_res_t;

  function automatic logic is_mul_op(input logic [W-1:0] op_ir);
    return (op_ir[7:6] == 2'b10) && (op_ir[5:3] == 3'b000) && (op_ir[1:0] == 2'b11);
  endfunction

  // Single-cycle ops; anything that is not LOAD/ALU-A/ALU-B returns a and fl untouched.
  function automatic alu_res_t alu(input logic [W-1:0] op_ir, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [3:0] fl);
    alu_res_t   res;
    logic [W:0] wide;
    logic       c;
    logic       v;
    logic [2:0] sh;
    res  = '{r: a, fl: fl};
    wide = '0;
    c    = 1'b0;
    v    = 1'b0;
    sh   = b[2:0];
    if (op_ir[5:3] == 3'b000) begin
      case (op_ir[7:6])
        2'b00: begin
          if (op_ir[1:0] == 2'b01) begin
            res.r  = b;
            res.fl = {fl[3], b[W-1], fl[1], (b == '0)};
          end
        end
        2'b01: begin
          case (op_ir[1:0])
            2'b00: begin
              wide  = {1'b0, a} + {1'b0, b};
              c     = wide[W];
              v     = (a[W-1] == b[W-1]) && (wide[W-1] != a[W-1]);
              res.r = wide[W-1:0];
            end
            2'b01: begin
              wide  = {1'b0, a} - {1'b0, b};
              c     = wide[W];
              v     = (a[W-1] != b[W-1]) && (wide[W-1] != a[W-1]);
              res.r = wide[W-1:0];
            end
            2'b10:   res.r = a & b;
            default: res.r = a | b;
          endcase
          res.fl = {v, res.r[W-1], c, (res.r == '0)};
        end
        2'b10: begin
          if (op_ir[1:0] != 2'b11) begin
            case (op_ir[1:0])
              2'b00: res.r = a ^ b;
              2'b01: begin
                // Extra bit above the MSB catches the last bit shifted out (0 for sh==0).
                wide  = {1'b0, a} << sh;
                c     = wide[W];
                res.r = wide[W-1:0];
              end
              default: begin
                wide  = {a, 1'b0} >> sh;
                c     = wide[0];
                res.r = wide[W:1];
              end
            endcase
            res.fl = {1'b0, res.r[W-1], c, (res.r == '0)};
          end
        end
        default: ;
      endcase
    end
    return res;
  endfunction

  state_t         state;
  state_t         state_next;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] mcand;
  logic [2*W-1:0] prod;
  logic [2*W-1:0] prod_step;
  logic [W-1:0]   mplier;

  logic           pend_valid;
  logic [W-1:0]   pend_ir;
  logic [W-1:0]   pend_ibr;
  logic [W-1:0]   pend_mbr;

  logic           mul_done;
  logic [W-1:0]   base_ar;
  logic [W-1:0]   base_ah;
  logic [3:0]     base_flags;
  logic           iss_valid;
  logic           iss_from_pend;
  logic [W-1:0]   iss_ir;
  logic [W-1:0]   iss_ibr;
  logic [W-1:0]   iss_mbr;
  logic [W-1:0]   iss_op;
  logic           start_mul;
  logic           slot_load;
  logic           drop;
  alu_res_t       alu_out;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (arst) state <= S_IDLE;
    else      state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start_mul) state_next = S_MUL;
      S_MUL:   if (mul_done) state_next = start_mul ? S_MUL : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state == S_MUL);
  end

  assign mul_done  = busy && (cnt == CW'(1));
  assign prod_step = prod + (mplier[0] ? mcand : '0);

  // On the completion edge the product is the AR/AH/flags any co-issued op builds on.
  always_comb begin
    base_ar    = ar;
    base_ah    = ah;
    base_flags = flags;
    if (mul_done) begin
      base_ar    = prod_step[W-1:0];
      base_ah    = prod_step[2*W-1:W];
      base_flags = {1'b0, 1'b0, (|prod_step[2*W-1:W]), (prod_step == '0)};
    end
  end

  // NOTE: every variable gets a default before any branch so always_comb never infers a latch.
  always_comb begin
    iss_valid     = 1'b0;
    iss_from_pend = 1'b0;
    iss_ir        = pend_valid ? pend_ir  : ir;
    iss_ibr       = pend_valid ? pend_ibr : ibr;
    iss_mbr       = pend_valid ? pend_mbr : mbr;
    if (!busy) begin
      iss_valid     = pend_valid || exec;
      iss_from_pend = pend_valid;
    end else if (mul_done) begin
      // A pending MUL chains straight on; a pending single-cycle op waits one cycle in IDLE.
      if (pend_valid) begin
        iss_valid     = is_mul_op(pend_ir);
        iss_from_pend = iss_valid;
      end else begin
        iss_valid = exec;
      end
    end
  end

  assign iss_op    = iss_ir[2] ? iss_ibr : iss_mbr;
  assign start_mul = iss_valid && is_mul_op(iss_ir);
  assign alu_out   = alu(iss_ir, base_ar, iss_op, base_flags);
  assign slot_load = exec && ((busy && !pend_valid && !mul_done) || (!busy && pend_valid));
  assign drop      = exec && busy && pend_valid;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (arst) begin
      ar         <= '0;
      ah         <= '0;
      flags      <= '0;
      ovr        <= 1'b0;
      cnt        <= '0;
      pend_valid <= 1'b0;
    end else begin
      ar    <= base_ar;
      ah    <= base_ah;
      flags <= base_flags;
      if (iss_valid && !start_mul) begin
        ar    <= alu_out.r;
        flags <= alu_out.fl;
      end
      if (drop) ovr <= 1'b1;
      if (start_mul)  cnt <= CW'(W);
      else if (busy)  cnt <= cnt - CW'(1);
      if (slot_load)          pend_valid <= 1'b1;
      else if (iss_from_pend) pend_valid <= 1'b0;
    end
  end

  // NOTE: slot contents and multiplier datapath need no reset; pend_valid/state gate every use.
  always_ff @(posedge clk) begin
    if (slot_load) begin
      pend_ir  <= ir;
      pend_ibr <= ibr;
      pend_mbr <= mbr;
    end
    if (start_mul) begin
      mcand  <= {{W{1'b0}}, base_ar};
      mplier <= iss_op;
      prod   <= '0;
    end else if (busy) begin
      prod   <= prod_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: directed scenarios plus a random single-cycle stream
// checked against an integer reference model.
module tb_exec_unit;

  localparam logic [7:0] LOAD_X  = 8'h01;
  localparam logic [7:0] LOAD_I  = 8'h05;
  localparam logic [7:0] STORE_X = 8'h02;
  localparam logic [7:0] JZ      = 8'hC0;
  localparam logic [7:0] ADD_I   = 8'h44;
  localparam logic [7:0] SUB_X   = 8'h41;
  localparam logic [7:0] SUB_I   = 8'h45;
  localparam logic [7:0] SHL_I   = 8'h85;
  localparam logic [7:0] SHR_I   = 8'h86;
  localparam logic [7:0] MUL_I   = 8'h87;

  logic       clk = 1'b0;
  logic       arst;
  logic       exec;
  logic [7:0] ir;
  logic [7:0] ibr;
  logic [7:0] mbr;
  logic [7:0] ar;
  logic [7:0] ah;
  logic [3:0] flags;
  logic       busy;
  logic       ovr;

  exec_unit #(.DATA_WIDTH(8)) dut (
    .clk   (clk),
    .arst  (arst),
    .exec  (exec),
    .ir    (ir),
    .ibr   (ibr),
    .mbr   (mbr),
    .ar    (ar),
    .ah    (ah),
    .flags (flags),
    .busy  (busy),
    .ovr   (ovr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [7:0] ar;
    logic [7:0] ah;
    logic [3:0] flags;
    string      name;
  } exp_t;

  exp_t       exp_q[$];
  int         total = 0;
  int         bad   = 0;
  logic [7:0] m_ar;
  logic [7:0] m_ah;
  logic [3:0] m_flags;

  // Integer reference model for single-cycle ops.
  function automatic void model(input logic [7:0] i, input logic [7:0] b_imm, input logic [7:0] b_mem);
    int a, b, r, n;
    bit c, v;
    a = m_ar;
    b = i[2] ? b_imm : b_mem;
    r = a; c = 0; v = 0;
    if (i[5:3] != 3'b000 || i[7:6] == 2'b11) return;
    if (i[7:6] == 2'b00) begin
      if (i[1:0] == 2'b01) begin
        m_ar       = b[7:0];
        m_flags[0] = (b == 0);
        m_flags[2] = (b >= 128);
      end
      return;
    end
    if (i[7:6] == 2'b01) begin
      case (i[1:0])
        2'b00: begin r = a + b; c = r > 255; r = r % 256;
                     v = ((a >= 128) == (b >= 128)) && ((r >= 128) != (a >= 128)); end
        2'b01: begin c = a < b; r = (a - b + 256) % 256;
                     v = ((a >= 128) != (b >= 128)) && ((r >= 128) != (a >= 128)); end
        2'b10: r = a & b;
        default: r = a | b;
      endcase
    end else begin
      n = b % 8;
      case (i[1:0])
        2'b00: r = a ^ b;
        2'b01: begin r = (a * (1 << n)) % 256; c = (n > 0) && (((a >> (8 - n)) % 2) == 1); end
        2'b10: begin r = a >> n; c = (n > 0) && (((a >> (n - 1)) % 2) == 1); end
        default: return;
      endcase
    end
    m_ar    = r[7:0];
    m_flags = {v, (r >= 128), c, (r == 0)};
  endfunction

  // Drive one exec cycle (called at a negedge); optionally push the state expected lat cycles after the exec edge.
  task automatic issue(input logic [7:0] i, input logic [7:0] b_imm, input logic [7:0] b_mem,
                       input bit chk, input int lat, input logic [7:0] e_ar, input logic [7:0] e_ah,
                       input logic [3:0] e_fl, input string name);
    exp_t e;
    if (chk) begin
      e.due = cyc + 1 + lat; e.ar = e_ar; e.ah = e_ah; e.flags = e_fl; e.name = name;
      exp_q.push_back(e);
    end
    exec = 1'b1; ir = i; ibr = b_imm; mbr = b_mem;
    @(negedge clk);
    exec = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        total++;
        if (e.due != cyc) begin
          bad++;
          $display("FAIL %s: missed at cycle %0d (due %0d)", e.name, cyc, e.due);
        end else if ({ar, ah, flags} !== {e.ar, e.ah, e.flags}) begin
          bad++;
          $display("FAIL %s: ar/ah/flags=%h/%h/%h expected %h/%h/%h",
                   e.name, ar, ah, flags, e.ar, e.ah, e.flags);
        end
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      total++; bad++;
      $display("FAIL drain: %0d results never produced, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    arst = 1'b1; exec = 1'b0; ir = '0; ibr = '0; mbr = '0;
    repeat (3) @(negedge clk);
    arst = 1'b0;
    total++;
    if ({ar, ah, flags, busy, ovr} !== 22'h0) begin
      bad++;
      $display("FAIL reset: ar/ah/flags/busy/ovr=%h/%h/%h/%b/%b required all zero", ar, ah, flags, busy, ovr);
    end
  endtask

  task automatic test_add();
    issue(LOAD_I, 8'h7F, 8'h00, 1, 0, 8'h7F, 8'h00, 4'h0, "load_7f"); idle(2);
    issue(ADD_I,  8'h01, 8'h00, 1, 0, 8'h80, 8'h00, 4'hC, "add_ovf"); idle(2);
    drain();
  endtask

  task automatic test_sub();
    issue(LOAD_I, 8'h05, 8'h00, 1, 0, 8'h05, 8'h00, 4'h8, "load_05");    idle(2);
    issue(SUB_X,  8'h00, 8'h05, 1, 0, 8'h00, 8'h00, 4'h1, "sub_zero");   idle(2);
    issue(SUB_I,  8'h01, 8'h00, 1, 0, 8'hFF, 8'h00, 4'h6, "sub_borrow"); idle(2);
    issue(LOAD_X, 8'h00, 8'h42, 1, 0, 8'h42, 8'h00, 4'h2, "load_x");     idle(2);
    drain();
  endtask

  task automatic test_shift();
    issue(LOAD_I, 8'h81, 8'h00, 1, 0, 8'h81, 8'h00, 4'h6, "load_81"); idle(2);
    issue(SHL_I,  8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 4'h2, "shl_1");   idle(2);
    issue(SHR_I,  8'h00, 8'h00, 1, 0, 8'h02, 8'h00, 4'h0, "shr_0");   idle(2);
    issue(SHR_I,  8'h02, 8'h00, 1, 0, 8'h00, 8'h00, 4'h3, "shr_2");   idle(2);
    drain();
  endtask

  task automatic test_mul();
    int n;
    issue(LOAD_I, 8'hFF, 8'h00, 1, 0, 8'hFF, 8'h00, 4'h6, "load_ff"); idle(2);
    issue(MUL_I,  8'hFF, 8'h00, 1, 8, 8'h01, 8'hFE, 4'h2, "mul_ff");
    n = 0;
    while (busy === 1'b1 && n < 20) begin n++; @(negedge clk); end
    total++;
    if (n != 8) begin bad++; $display("FAIL mul_busy_len: busy cycles=%0d required 8", n); end
    issue(LOAD_I, 8'h00, 8'h00, 1, 0, 8'h00, 8'hFE, 4'h3, "load_00"); idle(2);
    issue(MUL_I,  8'hFF, 8'h00, 1, 8, 8'h00, 8'h00, 4'h1, "mul_zero"); idle(9);
    drain();
  endtask

  task automatic test_nop();
    issue(LOAD_I,  8'h9C, 8'h00, 1, 0, 8'h9C, 8'h00, 4'h4, "load_9c");  idle(2);
    issue(STORE_X, 8'hBB, 8'hAA, 1, 0, 8'h9C, 8'h00, 4'h4, "store_x");  idle(2);
    issue(JZ,      8'h01, 8'h01, 1, 0, 8'h9C, 8'h00, 4'h4, "jz");       idle(2);
    issue(8'h4C,   8'h77, 8'h77, 1, 0, 8'h9C, 8'h00, 4'h4, "unused");   idle(2);
    drain();
  endtask

  task automatic test_back_to_back();
    issue(LOAD_I, 8'h03, 8'h00, 1, 0, 8'h03, 8'h00, 4'h0, "load_03"); idle(2);
    issue(MUL_I,  8'h05, 8'h00, 0, 0, 8'h00, 8'h00, 4'h0, "");        idle(7);
    issue(ADD_I,  8'h01, 8'h00, 1, 0, 8'h10, 8'h00, 4'h0, "add_on_done");
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy: busy=%b required 0", busy); end
    idle(2);
    issue(LOAD_I, 8'h02, 8'h00, 1, 0, 8'h02, 8'h00, 4'h0, "load_02"); idle(2);
    issue(MUL_I,  8'h03, 8'h00, 0, 0, 8'h00, 8'h00, 4'h0, "");        idle(2);
    issue(MUL_I,  8'h04, 8'h00, 1, 13, 8'h18, 8'h00, 4'h0, "mul_chain"); idle(5);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL chain_busy: busy=%b required 1", busy); end
    drain();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL chain_idle: busy=%b required 0", busy); end
  endtask

  task automatic test_pending_overrun();
    issue(LOAD_I, 8'h10, 8'h00, 1, 0, 8'h10, 8'h00, 4'h0, "load_10"); idle(2);
    issue(MUL_I,  8'h10, 8'h00, 1, 8, 8'h00, 8'h01, 4'h2, "mul_10");  idle(2);
    issue(ADD_I,  8'h01, 8'h00, 1, 6, 8'h01, 8'h01, 4'h0, "pend_add");
    total++;
    if (ovr !== 1'b0) begin bad++; $display("FAIL ovr_clear: ovr=%b required 0", ovr); end
    idle(2);
    issue(LOAD_I, 8'h55, 8'h00, 0, 0, 8'h00, 8'h00, 4'h0, "");
    total++;
    if (ovr !== 1'b1) begin bad++; $display("FAIL ovr_set: ovr=%b required 1", ovr); end
    drain();
    idle(3);
    total++;
    if (ar !== 8'h01) begin bad++; $display("FAIL dropped_noeffect: ar=%h required 01", ar); end
  endtask

  task automatic test_reset_mid_mul();
    issue(LOAD_I, 8'h20, 8'h00, 1, 0, 8'h20, 8'h01, 4'h0, "load_20"); idle(2);
    drain();
    issue(MUL_I,  8'h03, 8'h00, 0, 0, 8'h00, 8'h00, 4'h0, ""); idle(1);
    issue(ADD_I,  8'h01, 8'h00, 0, 0, 8'h00, 8'h00, 4'h0, ""); idle(1);
    arst = 1'b1;
    @(negedge clk);
    arst = 1'b0;
    total++;
    if ({ar, ah, flags, busy, ovr} !== 22'h0) begin
      bad++;
      $display("FAIL mid_reset: ar/ah/flags/busy/ovr=%h/%h/%h/%b/%b required all zero", ar, ah, flags, busy, ovr);
    end
    idle(8);
    total++;
    if ({ar, ah, flags, busy} !== 21'h0) begin
      bad++;
      $display("FAIL aborted_quiet: ar/ah/flags/busy=%h/%h/%h/%b required all zero", ar, ah, flags, busy);
    end
    issue(LOAD_I, 8'h33, 8'h00, 1, 0, 8'h33, 8'h00, 4'h0, "load_33"); idle(2);
    drain();
  endtask

  task automatic test_random();
    logic [7:0] i, bi, bm;
    m_ar = 8'h33; m_ah = 8'h00; m_flags = 4'h0;
    for (int k = 0; k < 30; k++) begin
      bi = 8'($urandom_range(0, 255));
      bm = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 4))
        0:       i = {2'b00, 3'b000, 1'($urandom_range(0, 1)), 2'b01};
        1:       i = {2'b01, 3'b000, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
        2, 3:    i = {2'b10, 3'b000, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
        default: i = {2'b11, 6'($urandom_range(0, 63))};
      endcase
      model(i, bi, bm);
      issue(i, bi, bm, 1, 0, m_ar, m_ah, m_flags, "random");
      idle(2);
    end
    drain();
  endtask

  initial begin
    arst = 1'b1; exec = 1'b0; ir = '0; ibr = '0; mbr = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_add();
    test_sub();
    test_shift();
    test_mul();
    test_nop();
    test_back_to_back();
    test_pending_overrun();
    test_reset_mid_mul();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
